acc_sram: RTL and testbench

- Parametrised successor to the team's 16x32 scratch SRAM.
- Separate write and read ports, so one write and one read can happen in the same cycle.
- Write port supports per-byte enables and an accumulate mode (read-modify-write add), for TPU partial-sum buffering.
- Read port has a configurable pipelined latency with a valid strobe. A hardware clear engine zeroes the array after reset or on request.

---
 rtl/acc_sram_pkg.sv | 21 ++
 rtl/acc_sram_rdpipe.sv | 45 ++++
 rtl/acc_sram.sv | 140 ++++++++++++++
 tb/tb_acc_sram.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_sram_pkg.sv
// Shared types and helpers for the accumulating scratch SRAM.
// Holds the control FSM state encoding and the write-mode constants.
// Imported by the top and by the read pipeline.
package acc_sram_pkg;

  // Control FSM: CLEAR walks the array writing zeros, IDLE serves traffic.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Write-mode encoding of the wr_acc input.
  localparam logic WR_OVR = 1'b0;
  localparam logic WR_ACC = 1'b1;

  // Number of byte lanes in a word of the given width.
  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/acc_sram_rdpipe.sv
// Read delay line: RD_LAT register stages carrying a valid bit and a data word.
// Latency RD_LAT cycles; one new entry per cycle, no stalls.
// Data registers only load on valid, so the output holds its last value.
module acc_sram_rdpipe
  import acc_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              vld [RD_LAT];
  logic [DATA_W-1:0] dat [RD_LAT];

  // Shift valid every cycle; move data only alongside a valid entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        dat[0] <= in_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/acc_sram.sv
// Register-array scratch SRAM with byte-enable overwrite and accumulate writes.
// Read latency RD_LAT cycles, fully pipelined; writes take effect in one cycle.
// No backpressure: wr_ready low (clear engine running) drops writes and reads.
module acc_sram
  import acc_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W/8-1:0]    wr_be,
  input  logic                   wr_acc,
  output logic                   wr_ready,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic                   clear_req,
  output logic                   busy
);

  localparam int                NB       = nbytes(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  if ((DATA_W % 8) != 0 || DEPTH < 2 || RD_LAT < 1 || RD_LAT > 2) begin : g_bad_param
    $error("acc_sram: illegal parameter combination");
  end

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_in_rng;
  logic              rd_in_rng;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;

  // FSM state register; reset always restarts a full clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: clear finishes after the last word, IDLE waits for a clear request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (cnt == LAST_IDX) state_nxt = ST_IDLE;
      ST_IDLE:  if (clear_req)       state_nxt = ST_CLEAR;
      default:                       state_nxt = ST_CLEAR;
    endcase
  end

  // FSM outputs: traffic is only served in IDLE.
  always_comb begin
    busy     = (state == ST_CLEAR);
    wr_ready = (state == ST_IDLE);
  end

  // Clear counter: walks 0..DEPTH-1 in CLEAR and parks at 0 otherwise,
  // so every clear starts from word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ST_CLEAR && cnt != LAST_IDX) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Address decode: out-of-range addresses are redirected to word 0 for the
  // array lookup and masked off at the point of use.
  always_comb begin
    wr_in_rng = ({1'b0, wr_addr} < DEPTH_X);
    rd_in_rng = ({1'b0, rd_addr} < DEPTH_X);
    wr_idx    = wr_in_rng ? wr_addr : '0;
    rd_idx    = rd_in_rng ? rd_addr : '0;
    wr_fire   = rst_n && wr_ready && wr_en && wr_in_rng;
    rd_fire   = wr_ready && rd_en;
  end

  // Next value of the addressed word: full-word add in accumulate mode,
  // otherwise a byte-lane merge of the new data over the old word.
  always_comb begin
    wr_word = mem[wr_idx];
    if (wr_acc == WR_ACC) begin
      wr_word = mem[wr_idx] + wr_data;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          wr_word[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read sample is taken from the current array contents, which gives
  // read-first behaviour when a write hits the same word this cycle.
  always_comb begin
    rd_word = rd_in_rng ? mem[rd_idx] : '0;
  end

  // Array update: the clear engine owns the array in CLEAR, the write port in IDLE.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_fire) begin
      mem[wr_idx] <= wr_word;
    end
  end

  acc_sram_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

endmodule

// File: tb/tb_acc_sram.sv
// Bench for acc_sram: two instances (16 words / latency 1, 12 words / latency 2)
// checked every cycle against a behavioural model, plus literal directed checks.
module tb_acc_sram;

  logic        clk;
  logic        rst_n;
  logic        wr_en     [2];
  logic [3:0]  wr_addr   [2];
  logic [31:0] wr_data   [2];
  logic [3:0]  wr_be     [2];
  logic        wr_acc    [2];
  logic        wr_ready  [2];
  logic        rd_en     [2];
  logic [3:0]  rd_addr   [2];
  logic [31:0] rd_data   [2];
  logic        rd_valid  [2];
  logic        clear_req [2];
  logic        busy      [2];

  int tests = 0;
  int fails = 0;

  acc_sram #(.DATA_W(32), .DEPTH(16), .RD_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_be(wr_be[0]),
    .wr_acc(wr_acc[0]), .wr_ready(wr_ready[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .clear_req(clear_req[0]), .busy(busy[0])
  );

  acc_sram #(.DATA_W(32), .DEPTH(12), .RD_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_be(wr_be[1]),
    .wr_acc(wr_acc[1]), .wr_ready(wr_ready[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .clear_req(clear_req[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm      [2][16];
  int          bl      [2];       // clear cycles still to run (0 = serving traffic)
  bit          ev      [2][64];   // expected read result due after edge index (mod 64)
  logic [31:0] ed      [2][64];
  logic [31:0] last_d  [2];
  int          vcnt    [2];
  int          edge_n  = 0;
  bit          started = 0;

  always @(posedge clk) begin
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        started = 1;
        bl[d] = dep(d);
        last_d[d] = '0;
        for (int i = 0; i < 64; i++) ev[d][i] = 0;
        for (int i = 0; i < 16; i++) mm[d][i] = '0;
      end else if (bl[d] > 0) begin
        bl[d]--;
      end else begin
        if (rd_en[d]) begin
          int s;
          s = (edge_n + lat(d) - 1) % 64;
          ev[d][s] = 1;
          ed[d][s] = (int'(rd_addr[d]) < dep(d)) ? mm[d][rd_addr[d]] : 32'h0;
        end
        if (wr_en[d] && int'(wr_addr[d]) < dep(d)) begin
          if (wr_acc[d]) begin
            mm[d][wr_addr[d]] = mm[d][wr_addr[d]] + wr_data[d];
          end else begin
            for (int b = 0; b < 4; b++)
              if (wr_be[d][b]) mm[d][wr_addr[d]][8*b +: 8] = wr_data[d][8*b +: 8];
          end
        end
        if (clear_req[d]) begin
          bl[d] = dep(d);
          for (int i = 0; i < 16; i++) mm[d][i] = '0;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        int e;
        e = edge_n % 64;
        chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(bl[d] > 0));
        chk($sformatf("wr_ready%0d", d), 32'(wr_ready[d]), 32'(bl[d] == 0));
        if (rd_valid[d]) vcnt[d]++;
        if (ev[d][e]) begin
          chk($sformatf("rd_valid%0d", d), 32'(rd_valid[d]), 32'd1);
          chk($sformatf("rd_data%0d", d), rd_data[d], ed[d][e]);
          last_d[d] = ed[d][e];
          ev[d][e] = 0;
        end else begin
          chk($sformatf("rd_valid%0d", d), 32'(rd_valid[d]), 32'd0);
          chk($sformatf("rd_hold%0d", d), rd_data[d], last_d[d]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int d, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input logic acc, input logic re, input logic [3:0] ra,
                    input logic clr);
    wr_en[d] = we; wr_addr[d] = wa; wr_data[d] = wd; wr_be[d] = be; wr_acc[d] = acc;
    rd_en[d] = re; rd_addr[d] = ra; clear_req[d] = clr;
    step();
    wr_en[d] = 1'b0; rd_en[d] = 1'b0; clear_req[d] = 1'b0;
  endtask

  // Called right after the accepting edge; measures latency in cycles.
  task automatic wait_rd(input int d, input logic [31:0] exp, input string nm);
    int k;
    k = 1;
    while (!rd_valid[d] && k < 6) begin
      step();
      k++;
    end
    chk({nm, "_lat"}, 32'(k), 32'(lat(d)));
    chk({nm, "_dat"}, rd_data[d], exp);
  endtask

  task automatic rd_lit(input int d, input logic [3:0] a, input logic [31:0] exp, input string nm);
    go(d, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 1'b1, a, 1'b0);
    wait_rd(d, exp, nm);
  endtask

  task automatic wr(input int d, input logic [3:0] a, input logic [31:0] v, input logic [3:0] be,
                    input logic acc);
    go(d, 1'b1, a, v, be, acc, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0, n1, v;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 0; wr_addr[d] = 0; wr_data[d] = 0; wr_be[d] = 0; wr_acc[d] = 0;
      rd_en[d] = 0; rd_addr[d] = 0; clear_req[d] = 0; vcnt[d] = 0;
    end
    step();
    rst_n = 1'b1;

    // Reset state and clear duration.
    chk("rst_busy", 32'(busy[0]), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready[0]), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid[0]), 32'd0);
    chk("rst_rd_data", rd_data[0], 32'd0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40 && (busy[0] || busy[1]); i++) begin
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      step();
    end
    chk("clear_len16", 32'(n0), 32'd16);
    chk("clear_len12", 32'(n1), 32'd12);
    for (int a = 0; a < 16; a++) rd_lit(0, 4'(a), 32'h0, "post_rst");
    rd_lit(1, 4'd11, 32'h0, "post_rst1");

    // Byte-enable overwrite, then an all-zero enable that must not change anything.
    wr(0, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0);
    wr(0, 4'd3, 32'h11223344, 4'b0101, 1'b0);
    rd_lit(0, 4'd3, 32'hAA22CC44, "byte_en");
    wr(0, 4'd3, 32'hDEADBEEF, 4'h0, 1'b0);
    rd_lit(0, 4'd3, 32'hAA22CC44, "be_zero");

    // Accumulate with wrap-around, three back-to-back updates.
    wr(0, 4'd5, 32'hFFFFFFF0, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) wr(0, 4'd5, 32'h20, 4'h0, 1'b1);
    rd_lit(0, 4'd5, 32'h00000050, "acc_wrap");

    // Read/write collision is read-first.
    wr(0, 4'd7, 32'h5, 4'hF, 1'b0);
    go(0, 1'b1, 4'd7, 32'h9, 4'hF, 1'b0, 1'b1, 4'd7, 1'b0);
    wait_rd(0, 32'h5, "collide_old");
    rd_lit(0, 4'd7, 32'h9, "collide_new");

    // Clear request alongside a read; writes during the clear are dropped.
    wr(0, 4'd2, 32'h77, 4'hF, 1'b0);
    go(0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1);
    wait_rd(0, 32'h77, "clr_inflight");
    n0 = 0;
    for (int i = 0; i < 40 && busy[0]; i++) begin
      n0++;
      wr(0, 4'd4, 32'h1234, 4'hF, 1'b0);
    end
    chk("clr_req_len", 32'(n0), 32'd16);
    rd_lit(0, 4'd2, 32'h0, "clr_addr2");
    rd_lit(0, 4'd4, 32'h0, "clr_dropped_wr");

    // Latency-2, 12-word instance: streaming reads and an out-of-range address.
    for (int a = 0; a < 12; a++) wr(1, 4'(a), 32'h100 + 32'(a), 4'hF, 1'b0);
    wr(1, 4'd13, 32'hCAFE, 4'hF, 1'b0);
    v = vcnt[1];
    for (int a = 0; a < 12; a++) go(1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 1'b1, 4'(a), 1'b0);
    repeat (3) step();
    chk("stream_pulses", 32'(vcnt[1] - v), 32'd12);
    rd_lit(1, 4'd5, 32'h105, "lat2_word");
    rd_lit(1, 4'd13, 32'h0, "oor_read");

    // Randomized traffic with occasional clears and one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        wr_en[d]     = 1'($urandom);
        wr_addr[d]   = ($urandom % 2) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        wr_data[d]   = ($urandom % 2) ? 32'($urandom) : 32'($urandom_range(0, 255));
        wr_be[d]     = 4'($urandom);
        wr_acc[d]    = ($urandom % 3) == 0;
        rd_en[d]     = 1'($urandom);
        rd_addr[d]   = ($urandom % 2) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        clear_req[d] = ($urandom % 80) == 0;
      end
      rst_n = (c != 1500);
      step();
    end
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 0; rd_en[d] = 0; clear_req[d] = 0;
    end
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
